regfile_arbiter: RTL
====================

REGFILE_ARBITER -- requirements
Module: regfile_arbiter

Interface
REQ-001 SHALL have parameter REG_WIDTH, default 32, data width of both requester ports and the register-file port.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 15, the maximum number of wait cycles for rf_valid (used only when the timeout feature is compiled in).
REQ-003 SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit, reset: asynchronous assertion, active-low.
REQ-005 SHALL have port req_valid, input, [1:0], per-requester command valid.
REQ-006 SHALL have port req_ready, output, [1:0], per-requester command accepted.
REQ-007 SHALL have port req_write, input, [1:0], per-requester write (1) or read (0).
REQ-008 SHALL have port req_addr, input, reg_e [1:0], per-requester register address.
REQ-009 SHALL have port req_wdata, input, [1:0][REG_WIDTH-1:0], per-requester write data.
REQ-010 SHALL have port rsp_valid, output, [1:0], per-requester response valid.
REQ-011 SHALL have port rsp_ready, input, [1:0], per-requester response accepted.
REQ-012 SHALL have port rsp_rdata, output, [REG_WIDTH-1:0], response read data, shared by both requesters.
REQ-013 SHALL have port rsp_err, output, 1 bit, response error flag, shared by both requesters.
REQ-014 SHALL have ports RegWrite, addr (reg_e), write_data [REG_WIDTH-1:0] as outputs, and read_data [REG_WIDTH-1:0], valid as inputs, connecting to the register-file DUT modport.

Function
REQ-015 SHALL implement FSM IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
REQ-016 In IDLE with any req_valid, SHALL grant one requester, pulse its req_ready for 1 cycle, latch write/addr/wdata, and go to ISSUE.
REQ-017 Arbitration SHALL be round-robin: on simultaneous requests, grant the requester named by a priority pointer; the pointer SHALL move to the other requester after every grant.
REQ-018 In ISSUE, SHALL drive addr/write_data from the latched command and assert RegWrite for exactly 1 cycle if a write (0 if a read); next state WAIT.
REQ-019 In WAIT, SHALL hold addr/write_data stable with RegWrite=0 until valid=1; then capture read_data (reads) or zero (writes) into rsp_rdata, set rsp_err=0, and go to RESP.
REQ-020 If valid=1 in the ISSUE cycle itself, SHALL still pass through WAIT and sample valid there; minimum accept-to-rsp_valid latency is 3 cycles.
REQ-021 A latched addr outside the defined reg_e encodings SHALL skip ISSUE/WAIT, go directly to RESP with rsp_err=1, rsp_rdata=0, and RegWrite never asserted.
REQ-022 In RESP, SHALL assert rsp_valid only for the granted requester and hold rsp_rdata/rsp_err stable until that requester's rsp_ready=1; then go to IDLE.
REQ-023 Only one command SHALL be outstanding; req_ready SHALL be 0 outside IDLE.
REQ-024 A requester dropping req_valid before grant SHALL NOT be served.

Reset
REQ-025 On rst_n=0, SHALL go to IDLE immediately; req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, RegWrite=0, addr=first reg_e value, write_data=0, priority pointer=0, timeout counter=0.
REQ-026 Reset during ISSUE/WAIT/RESP SHALL abandon the command; no response SHALL be issued afterwards.

Configuration
REQ-027 With macro REGFILE_ARB_TIMEOUT_EN defined, SHALL count WAIT cycles; if the count reaches TIMEOUT_CYCLES without valid, SHALL go to RESP with rsp_err=1 and rsp_rdata=0. The counter SHALL clear on entering WAIT.
REQ-028 Without REGFILE_ARB_TIMEOUT_EN, SHALL wait in WAIT indefinitely, and no counter SHALL exist.

Structure
REQ-029 reg_e and REG_WIDTH SHALL come from shared_pkg; the FSM state enum arb_state_e SHALL be added to shared_pkg.
REQ-030 The round-robin grant logic SHALL be a sub-module rr_arbiter2 (inputs req[1:0] and advance; output grant[1:0] one-hot; pointer held internally).

Verification
REQ-031 Requester 0 writes 0xDEADBEEF to reg 2, valid returned 1 cycle after ISSUE -> RegWrite pulses once; rsp_valid[0] arrives 3 cycles after accept with rsp_err=0.
REQ-032 Both requesters read in the same cycle after reset -> requester 0 is granted first, then requester 1; a following simultaneous pair grants requester 0 again.
REQ-033 Read of reg 4 holding 0x12345678 with rsp_ready held 0 for 5 cycles -> rsp_rdata=0x12345678 held stable and req_ready=0 throughout.
REQ-034 Illegal addr encoding 7 -> rsp_err=1, rsp_rdata=0, RegWrite stays 0 and addr is not driven to the register file.
REQ-035 With REGFILE_ARB_TIMEOUT_EN and valid tied to 0 -> rsp_err=1 after 15 WAIT cycles; without the macro -> no response after 100 cycles.
REQ-036 rst_n asserted during WAIT -> outputs reach reset values without waiting for a clock edge, and no rsp_valid follows.

Source files
------------

// File: rtl/shared_pkg.sv
// Types shared by the register-file arbiter and its register-file neighbour:
// data width, register address encoding and the arbiter FSM states.
package shared_pkg;

  localparam int REG_WIDTH = 32;

  // Encodings 6 and 7 are deliberately unassigned and must be rejected.
  typedef enum logic [2:0] {
    REG_0 = 3'd0,
    REG_1 = 3'd1,
    REG_2 = 3'd2,
    REG_3 = 3'd3,
    REG_4 = 3'd4,
    REG_5 = 3'd5
  } reg_e;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } arb_state_e;

  function automatic logic is_legal_reg(input logic [2:0] raw_addr);
    return raw_addr <= 3'(REG_5);
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter: grants the pointed-to requester first and
// moves the pointer to the other requester whenever a grant is taken.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant
);

  logic ptr_q;
  logic ptr_d;

  always_comb begin
    grant = 2'b00;
    if (req[ptr_q]) begin
      grant[ptr_q] = 1'b1;
    end else if (req[!ptr_q]) begin
      grant[!ptr_q] = 1'b1;
    end
  end

  // After granting requester 0 point at 1, after granting 1 point at 0.
  always_comb begin
    ptr_d = ptr_q;
    if (advance && (grant != 2'b00)) begin
      ptr_d = grant[0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/regfile_arbiter.sv
// Arbitrates two requesters onto one register-file port, one command at a time.
// Define REGFILE_ARB_TIMEOUT_EN to bound the wait for the register file's valid.
module regfile_arbiter
  import shared_pkg::*;
#(
  parameter int REG_WIDTH      = shared_pkg::REG_WIDTH,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [1:0]                req_valid,
  output logic [1:0]                req_ready,
  input  logic [1:0]                req_write,
  input  reg_e [1:0]                req_addr,
  input  logic [1:0][REG_WIDTH-1:0] req_wdata,
  output logic [1:0]                rsp_valid,
  input  logic [1:0]                rsp_ready,
  output logic [REG_WIDTH-1:0]      rsp_rdata,
  output logic                      rsp_err,
  output logic                      RegWrite,
  output reg_e                      addr,
  output logic [REG_WIDTH-1:0]      write_data,
  input  logic [REG_WIDTH-1:0]      read_data,
  input  logic                      valid
);

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout_cfg
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  arb_state_e             state_q, state_d;
  logic [1:0]             gnt_q, gnt_d;
  logic                   cmd_write_q, cmd_write_d;
  reg_e                   addr_q, addr_d;
  logic [REG_WIDTH-1:0]   write_data_q, write_data_d;
  logic [REG_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                   rsp_err_q, rsp_err_d;

  logic [1:0] grant;
  logic       accept;
  logic       sel;

`ifdef REGFILE_ARB_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
`endif

  assign accept = (state_q == IDLE) && (grant != 2'b00);
  assign sel    = grant[1];

  rr_arbiter2 u_rr (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req_valid),
    .advance (accept),
    .grant   (grant)
  );

  always_comb begin
    // NOTE: every _d gets its hold value first, so no path through the case
    // statement can leave one unassigned and infer a latch.
    state_d      = state_q;
    gnt_d        = gnt_q;
    cmd_write_d  = cmd_write_q;
    addr_d       = addr_q;
    write_data_d = write_data_q;
    rsp_rdata_d  = rsp_rdata_q;
    rsp_err_d    = rsp_err_q;
`ifdef REGFILE_ARB_TIMEOUT_EN
    tmo_cnt_d    = tmo_cnt_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          gnt_d       = grant;
          cmd_write_d = req_write[sel];
          if (is_legal_reg(req_addr[sel])) begin
            addr_d       = req_addr[sel];
            write_data_d = req_wdata[sel];
            state_d      = ISSUE;
          end else begin
            // Bad address never reaches the register file.
            rsp_rdata_d = '0;
            rsp_err_d   = 1'b1;
            state_d     = RESP;
          end
        end
      end
      ISSUE: begin
`ifdef REGFILE_ARB_TIMEOUT_EN
        tmo_cnt_d = '0;
`endif
        state_d = WAIT;
      end
      WAIT: begin
        if (valid) begin
          rsp_rdata_d = cmd_write_q ? '0 : read_data;
          rsp_err_d   = 1'b0;
          state_d     = RESP;
        end
`ifdef REGFILE_ARB_TIMEOUT_EN
        else if (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b1;
          state_d     = RESP;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
`endif
      end
      RESP: begin
        if ((rsp_ready & gnt_q) != 2'b00) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      gnt_q        <= 2'b00;
      cmd_write_q  <= 1'b0;
      addr_q       <= REG_0;
      write_data_q <= '0;
      rsp_rdata_q  <= '0;
      rsp_err_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q      <= state_d;
      gnt_q        <= gnt_d;
      cmd_write_q  <= cmd_write_d;
      addr_q       <= addr_d;
      write_data_q <= write_data_d;
      rsp_rdata_q  <= rsp_rdata_d;
      rsp_err_q    <= rsp_err_d;
    end
  end

`ifdef REGFILE_ARB_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt_q <= '0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
    end
  end
`endif

  // rst_n gates the combinational ready so reset forces it low immediately.
  assign req_ready  = (state_q == IDLE && rst_n) ? grant : 2'b00;
  assign rsp_valid  = (state_q == RESP) ? gnt_q : 2'b00;
  assign RegWrite   = (state_q == ISSUE) && cmd_write_q;
  assign addr       = addr_q;
  assign write_data = write_data_q;
  assign rsp_rdata  = rsp_rdata_q;
  assign rsp_err    = rsp_err_q;

endmodule
